// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: 32-bit data, word-addressed array, independent read/write FSMs.
// The array is preloaded with FILL at configuration time and is never cleared by reset.
module axi4_slave_mem #(
  parameter int ADDR_W = 32,
  parameter int ID_W = 1,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0] FILL = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);
  localparam int DEPTH = 1 << MEM_WORDS_LOG2;
  localparam int SPAN_LOG2 = MEM_WORDS_LOG2 + 2;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] r_mem [DEPTH] = '{default: FILL};

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> SPAN_LOG2) == '0);
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] f_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return MEM_WORDS_LOG2'(off >> 2);
  endfunction

  function automatic logic f_illegal(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || burst[1];
  endfunction

  function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Gates both address readies low until the first edge after reset release
  logic r_up;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_up <= 1'b0;
    else     r_up <= 1'b1;
  end

  w_state_t              r_wstate, w_wnext;
  logic [ID_W-1:0]       r_bid;
  logic [ADDR_W-1:0]     r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic                  r_wincr, r_willegal;
  logic [1:0]            r_bresp, w_wbeat_resp;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_wen;
  logic [MEM_WORDS_LOG2-1:0] w_widx;

  assign w_aw_hs = s_axi_awready && s_axi_awvalid;
  assign w_w_hs = s_axi_wready && s_axi_wvalid;
  assign w_b_hs = s_axi_bvalid && s_axi_bready;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_widx = f_idx(r_waddr);
  assign w_wen = w_w_hs && !r_willegal && f_in_range(r_waddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wnext = W_RESP;
      W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = r_up && (r_wstate == W_IDLE);
    s_axi_wready = (r_wstate == W_DATA);
    s_axi_bvalid = (r_wstate == W_RESP);
  end

  // Beat count is authoritative; a misplaced wlast only flags SLVERR
  always_comb begin
    w_wbeat_resp = OKAY;
    if (r_willegal) w_wbeat_resp = SLVERR;
    else if (!f_in_range(r_waddr)) w_wbeat_resp = DECERR;
    if (s_axi_wlast != w_wlast_beat)
      w_wbeat_resp = f_worst(w_wbeat_resp, SLVERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bid <= '0;
      r_waddr <= '0;
      r_wlen <= '0;
      r_wcnt <= '0;
      r_wincr <= 1'b0;
      r_willegal <= 1'b0;
      r_bresp <= OKAY;
    end else if (w_aw_hs) begin
      r_bid <= s_axi_awid;
      r_waddr <= s_axi_awaddr;
      r_wlen <= s_axi_awlen;
      r_wcnt <= '0;
      r_wincr <= (s_axi_awburst == 2'b01);
      r_willegal <= f_illegal(s_axi_awsize, s_axi_awburst);
      r_bresp <= OKAY;
    end else if (w_w_hs) begin
      r_wcnt <= r_wcnt + 8'd1;
      r_waddr <= r_waddr + ADDR_W'(r_wincr ? 4 : 0);
      r_bresp <= f_worst(r_bresp, w_wbeat_resp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  assign s_axi_bid = r_bid;
  assign s_axi_bresp = r_bresp;

  r_state_t              r_rstate, w_rnext;
  logic [ID_W-1:0]       r_rid;
  logic [ADDR_W-1:0]     r_raddr, w_rsel_addr;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_rincr, r_rillegal, w_rsel_illegal;
  logic [31:0]           r_rdata, w_rbeat_data;
  logic [1:0]            r_rresp, w_rbeat_resp;
  logic                  r_rlast, w_ar_hs, w_r_hs;

  assign w_ar_hs = s_axi_arready && s_axi_arvalid;
  assign w_r_hs = s_axi_rvalid && s_axi_rready;

  // In idle the beat comes from the AR channel, otherwise from the burst pointer
  assign w_rsel_addr = (r_rstate == R_IDLE) ? s_axi_araddr : r_raddr;
  assign w_rsel_illegal = (r_rstate == R_IDLE) ?
    f_illegal(s_axi_arsize, s_axi_arburst) : r_rillegal;

  always_comb begin
    w_rbeat_data = '0;
    w_rbeat_resp = OKAY;
    if (w_rsel_illegal) w_rbeat_resp = SLVERR;
    else if (!f_in_range(w_rsel_addr)) w_rbeat_resp = DECERR;
    else w_rbeat_data = r_mem[f_idx(w_rsel_addr)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = r_up && (r_rstate == R_IDLE);
    s_axi_rvalid = (r_rstate == R_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rid <= '0;
      r_raddr <= '0;
      r_rlen <= '0;
      r_rcnt <= '0;
      r_rincr <= 1'b0;
      r_rillegal <= 1'b0;
      r_rdata <= '0;
      r_rresp <= OKAY;
      r_rlast <= 1'b0;
    end else if (w_ar_hs) begin
      r_rid <= s_axi_arid;
      r_rlen <= s_axi_arlen;
      r_rcnt <= '0;
      r_rincr <= (s_axi_arburst == 2'b01);
      r_rillegal <= w_rsel_illegal;
      r_raddr <= s_axi_araddr + ADDR_W'((s_axi_arburst == 2'b01) ? 4 : 0);
      r_rdata <= w_rbeat_data;
      r_rresp <= w_rbeat_resp;
      r_rlast <= (s_axi_arlen == 8'd0);
    end else if (w_r_hs && !r_rlast) begin
      r_rcnt <= r_rcnt + 8'd1;
      r_raddr <= r_raddr + ADDR_W'(r_rincr ? 4 : 0);
      r_rdata <= w_rbeat_data;
      r_rresp <= w_rbeat_resp;
      r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
    end
  end

  assign s_axi_rid = r_rid;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;
  assign s_axi_rlast = r_rlast;
endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

Synthesizable AXI4 memory slave with a 32-bit data bus. It is the responder side of the AXI master ports that bambu generates for HLS kernels such as the mmult accelerator, and replaces the vendor VIP slave memory model in vendor-neutral regression benches. Read and write channels run independent FSMs on a shared word-addressed array. Contents are preloaded from a fill value, and the array is never cleared by reset.

## Interface
- `ADDR_W`, 32: AXI address width.
- `ID_W`, 1: AXI ID width.
- `MEM_WORDS_LOG2`, 10: array depth is 2^MEM_WORDS_LOG2 32-bit words.
- `BASE_ADDR`, 0: byte address of word 0.
- `FILL`, 32'hFFFFFFFF: initial value of every word (initial block only; not applied on reset).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `s_axi_awid` in ID_W, `s_axi_awaddr` in ADDR_W, `s_axi_awlen` in 8, `s_axi_awsize` in 3, `s_axi_awburst` in 2, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wlast` in 1, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bid` out ID_W, `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_arid` in ID_W, `s_axi_araddr` in ADDR_W, `s_axi_arlen` in 8, `s_axi_arsize` in 3, `s_axi_arburst` in 2, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rid` out ID_W, `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rlast` out 1, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.

## Operation
- Address decode, per beat:
  - In range when BASE_ADDR <= addr < BASE_ADDR + 4·2^MEM_WORDS_LOG2.
  - Word index = (addr − BASE_ADDR) >> 2. Address bits [1:0] are ignored.
- Burst address: FIXED (00) repeats the start address; INCR (01) adds 4 per beat. 4 KB crossing is not checked.
- Errors, checked per burst:
  - Illegal burst: awsize/arsize ≠ 3'b010, or burst type WRAP (10) or 11. The whole burst gets SLVERR (10). Writes to memory are suppressed; read beats return rdata=0.
  - Out-of-range beat: that beat gets DECERR (11), with no write and rdata=0. The B response is the worst of all beats (DECERR > SLVERR > OKAY).
  - wlast mismatch: beat count (awlen+1) is authoritative. wlast asserted early, or missing on the final beat, raises SLVERR in B, but the data is still written.
- Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: awready=1. AW handshake latches id, addr, len, burst, error flag.
  - W_DATA: wready=1. Each W handshake writes bytes where wstrb[i]=1. After beat awlen+1 → W_RESP.
  - W_RESP: bvalid=1 with bid = latched awid. bvalid&bready → W_IDLE.
- Read FSM, states R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: arready=1. AR handshake latches the request and loads beat 0 into the registered rdata/rresp/rlast.
  - R_DATA: rvalid=1. Each rvalid&rready loads the next beat on the same edge. rlast=1 on beat arlen+1; its handshake → R_IDLE.
- The array is read combinationally; rdata is registered.
- Write and read of the same word on the same edge: the read returns the old data, and the write takes effect.
- One outstanding burst per direction; read and write proceed concurrently.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0. bresp, rresp, rdata, bid, rid = 0.
- awready and arready rise at the first rising edge after rst deasserts.
- AW handshake at edge k: wready=1 from k (after that edge). The last W handshake at edge j gives bvalid=1 from j. After the B handshake at edge m, awready=1 from m.
- AR handshake at edge k gives rvalid=1 from k. With rready held high, an N-beat burst completes at edge k+N, one beat per cycle. The last handshake at edge m gives arready=1 from m.
- Back-to-back bursts are not overlapped: each new burst has one idle-handshake cycle.
- Under backpressure (valid high, ready low), rdata, rresp, rlast, rid, bresp and bid stay stable, and valid stays high.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronously) and both FSMs go to IDLE. Words already written are retained; the remaining beats are lost.

## Test plan
- Single write of 0xDEADBEEF, wstrb 0xF, at BASE+0x10, awid=1, then a single read → bresp=00, bid=1; rdata=0xDEADBEEF, rresp=00, rlast=1, rid matches arid.
- Write 0x11223344 with wstrb 0b0101 to an unwritten word, then read → 0xFF22FF44.
- INCR write with awlen=3 of words 1,2,3,4 at BASE, then INCR read with arlen=3 and rready held 1 → beats 1,2,3,4 on 4 consecutive cycles, rlast only on beat 4. A FIXED read of arlen=1 at BASE returns 1,1.
- Read at BASE+4·2^MEM_WORDS_LOG2 → rresp=11, rdata=0. Write there → bresp=11, and word 0 is unchanged. A burst with awsize=3'b001 → bresp=10 and no memory change.
- Hold bready low for 5 cycles → bvalid held and awready stays 0. Toggle rready during a 4-beat read → rdata stable while stalled, data order intact.
- Assert rst during beat 2 of a 4-beat read and beat 2 of a concurrent 4-beat write → rvalid and wready drop immediately, arready=1 one edge after release. Write beat 1 persists; write beats 2–4 are absent.
